i2c_target_regfile: RTL and testbench

- I2C target (responder) on the same open-drain bus the Nios II system's I2C host drives.
- Holds a byte-addressed register file that the host writes and reads with standard register-pointer transactions.
- Used on-chip as a loopback/bring-up target for host firmware, and as a model of the HDMI transmitter's configuration port.
- Standard- and fast-mode only; 7-bit addressing; no clock stretching.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_filter.sv | 50 +++++
 rtl/i2c_target_regfile.sv | 162 ++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-file target: FSM encoding and bus constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WR_ACK,
        READ,
        HOST_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a stability filter; emits one-cycle rise/fall
// pulses coincident with the filtered level changing.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          filt_q, rise_q, fall_q;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                filt_q <= sync_q[1];
                rise_q <= sync_q[1];
                fall_q <= ~sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-addressed register file via register-pointer
// transactions; 7-bit addressing, no clock stretching.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         REG_COUNT = 256,
    parameter int         FILT_LEN  = 3
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       i2c_sda_in,
    input  logic       i2c_scl_in,
    output logic       i2c_sda_oe,
    output logic       i2c_scl_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int PW = $clog2(REG_COUNT);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .line_i(i2c_scl_in),
        .filt_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .line_i(i2c_sda_in),
        .filt_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e      state_q;
    logic [3:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic [PW-1:0]   ptr_q;
    logic            rw_q, sda_oe_q, busy_q, wr_strobe_q;
    logic [7:0]      wr_addr_q, wr_data_q;
    logic [7:0]      regs_q [REG_COUNT];

    // Committed bytes land one cycle after the strobe; reads load a full SCL period later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (wr_strobe_q) begin
            regs_q[wr_addr_q[PW-1:0]] <= wr_data_q;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (sda_fall && scl_f) begin
                state_q  <= ADDR;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
            end else if (sda_rise && scl_f) begin
                state_q  <= IDLE;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    ADDR, PTR, WRITE: if (bitcnt_q != 4'd8) begin
                        shift_q  <= {shift_q[6:0], sda_f};
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                    READ: bitcnt_q <= bitcnt_q + 1'b1;
                    HOST_ACK: if (sda_f == I2C_ACK) begin
                        ptr_q <= ptr_q + 1'b1;
                    end else begin
                        state_q <= IGNORE;
                        busy_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    ADDR: if (bitcnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_q  <= ADDR_ACK;
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            rw_q     <= shift_q[0];
                        end else begin
                            state_q <= IGNORE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ADDR_ACK: begin
                        bitcnt_q <= '0;
                        if (rw_q == I2C_RW_READ) begin
                            state_q  <= READ;
                            shift_q  <= regs_q[ptr_q];
                            sda_oe_q <= ~regs_q[ptr_q][7];
                        end else begin
                            state_q  <= PTR;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    PTR: if (bitcnt_q == 4'd8) begin
                        state_q  <= PTR_ACK;
                        sda_oe_q <= 1'b1;
                        ptr_q    <= shift_q[PW-1:0];
                    end
                    PTR_ACK, WR_ACK: begin
                        state_q  <= WRITE;
                        sda_oe_q <= 1'b0;
                        bitcnt_q <= '0;
                    end
                    WRITE: if (bitcnt_q == 4'd8) begin
                        state_q     <= WR_ACK;
                        sda_oe_q    <= 1'b1;
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= 8'(ptr_q);
                        wr_data_q   <= shift_q;
                        ptr_q       <= ptr_q + 1'b1;
                    end
                    READ: if (bitcnt_q == 4'd8) begin
                        state_q  <= HOST_ACK;
                        sda_oe_q <= 1'b0;
                        bitcnt_q <= '0;
                    end else begin
                        shift_q  <= {shift_q[6:0], 1'b0};
                        sda_oe_q <= ~shift_q[6];
                    end
                    // Only reachable after an ACK rise; NACK already left for IGNORE.
                    HOST_ACK: begin
                        state_q  <= READ;
                        bitcnt_q <= '0;
                        shift_q  <= regs_q[ptr_q];
                        sda_oe_q <= ~regs_q[ptr_q][7];
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign i2c_sda_oe = sda_oe_q;
    assign i2c_scl_oe = 1'b0;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-banged I2C host on an open-drain bus model around the target.
module tb_i2c_target_regfile;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_sda = 1'b1, host_scl = 1'b1;
    logic       sda_oe, scl_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data;
    logic       sda_bus, scl_bus;

    assign sda_bus = host_sda & ~sda_oe;
    assign scl_bus = host_scl & ~scl_oe;

    always #5 clk = ~clk;

    i2c_target_regfile dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .i2c_sda_in(sda_bus), .i2c_scl_in(scl_bus),
        .i2c_sda_oe(sda_oe), .i2c_scl_oe(scl_oe),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    logic [7:0] s_addr [$];
    logic [7:0] s_data [$];
    int         oe_cnt = 0, busy_cnt = 0;

    always @(posedge clk) begin
        if (wr_strobe) begin
            s_addr.push_back(wr_addr);
            s_data.push_back(wr_data);
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] qa(input int i);
        return (i < s_addr.size()) ? s_addr[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] qd(input int i);
        return (i < s_data.size()) ? s_data[i] : 8'hxx;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        host_sda = 1'b1; wait_n(Q);
        host_scl = 1'b1; wait_n(Q);
        host_sda = 1'b0; wait_n(Q);
        host_scl = 1'b0; wait_n(Q);
    endtask

    task automatic i2c_stop();
        host_sda = 1'b0; wait_n(Q);
        host_scl = 1'b1; wait_n(Q);
        host_sda = 1'b1; wait_n(Q);
    endtask

    // gl: one-cycle opposite-level pulse on SDA mid-way through each SCL-high phase
    task automatic send_byte(input logic [7:0] b, input bit gl, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            host_sda = b[i]; wait_n(Q);
            host_scl = 1'b1;
            if (gl) begin
                wait_n(5); host_sda = ~b[i]; wait_n(1); host_sda = b[i]; wait_n(2*Q-6);
            end else wait_n(2*Q);
            host_scl = 1'b0; wait_n(Q);
        end
        host_sda = 1'b1; wait_n(Q);
        host_scl = 1'b1; wait_n(Q);
        ack = sda_bus;   wait_n(Q);
        host_scl = 1'b0; wait_n(Q);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            host_sda = 1'b1; wait_n(Q);
            host_scl = 1'b1; wait_n(Q);
            b[i] = sda_bus;  wait_n(Q);
            host_scl = 1'b0; wait_n(Q);
        end
        host_sda = ack_bit; wait_n(Q);
        host_scl = 1'b1;    wait_n(2*Q);
        host_scl = 1'b0;    wait_n(Q);
        host_sda = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         base, oe0, busy0;

        wait_n(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1; wait_n(10);

        // Write two bytes starting at 0x10
        base = s_addr.size();
        i2c_start();
        send_byte(8'h72, 0, ack); check("wr_ack_addr", ack, 0);
        check("wr_busy_hi", busy, 1);
        send_byte(8'h10, 0, ack); check("wr_ack_ptr", ack, 0);
        send_byte(8'hA5, 0, ack); check("wr_ack_d0", ack, 0);
        send_byte(8'h5A, 0, ack); check("wr_ack_d1", ack, 0);
        i2c_stop(); wait_n(Q);
        check("wr_busy_lo", busy, 0);
        check("wr_scl_oe", scl_oe, 0);
        check("wr_nstrobe", s_addr.size() - base, 2);
        check("wr_addr0", qa(base), 8'h10);
        check("wr_data0", qd(base), 8'hA5);
        check("wr_addr1", qa(base+1), 8'h11);
        check("wr_data1", qd(base+1), 8'h5A);

        // Random read via repeated START
        base = s_addr.size();
        i2c_start();
        send_byte(8'h72, 0, ack); check("rd_ack_addr", ack, 0);
        send_byte(8'h10, 0, ack); check("rd_ack_ptr", ack, 0);
        i2c_start();
        send_byte(8'h73, 0, ack); check("rd_ack_raddr", ack, 0);
        read_byte(1'b0, rd); check("rd_byte0", rd, 8'hA5);
        read_byte(1'b1, rd); check("rd_byte1", rd, 8'h5A);
        check("rd_sda_released", sda_oe, 0);
        i2c_stop(); wait_n(Q);
        check("rd_no_strobe", s_addr.size() - base, 0);

        // Address mismatch
        base = s_addr.size(); oe0 = oe_cnt; busy0 = busy_cnt;
        i2c_start();
        send_byte(8'h74, 0, ack); check("mm_nack_addr", ack, 1);
        send_byte(8'h00, 0, ack); check("mm_nack_data", ack, 1);
        i2c_stop(); wait_n(Q);
        check("mm_oe_never", oe_cnt - oe0, 0);
        check("mm_no_strobe", s_addr.size() - base, 0);
        check("mm_busy_never", busy_cnt - busy0, 0);

        // Glitches on SDA while SCL high must not look like START/STOP
        base = s_addr.size();
        i2c_start();
        send_byte(8'h72, 0, ack);
        send_byte(8'h20, 0, ack);
        send_byte(8'hC3, 1, ack); check("gl_ack", ack, 0);
        check("gl_busy", busy, 1);
        i2c_stop(); wait_n(Q);
        check("gl_addr", qa(base), 8'h20);
        check("gl_data", qd(base), 8'hC3);

        // Pointer wrap 0xFF -> 0x00
        base = s_addr.size();
        i2c_start();
        send_byte(8'h72, 0, ack);
        send_byte(8'hFF, 0, ack);
        send_byte(8'h11, 0, ack);
        send_byte(8'h22, 0, ack);
        i2c_stop(); wait_n(Q);
        check("wrap_addr0", qa(base), 8'hFF);
        check("wrap_data0", qd(base), 8'h11);
        check("wrap_addr1", qa(base+1), 8'h00);
        check("wrap_data1", qd(base+1), 8'h22);
        i2c_start();
        send_byte(8'h72, 0, ack);
        send_byte(8'hFF, 0, ack);
        i2c_start();
        send_byte(8'h73, 0, ack);
        read_byte(1'b0, rd); check("wrap_rd_ff", rd, 8'h11);
        read_byte(1'b1, rd); check("wrap_rd_00", rd, 8'h22);
        i2c_stop(); wait_n(Q);

        // Reset while the target is pulling SDA low (reg[0]=0x22, MSB 0)
        i2c_start();
        send_byte(8'h72, 0, ack);
        send_byte(8'h00, 0, ack);
        i2c_start();
        send_byte(8'h73, 0, ack);
        check("rr_driving", sda_oe, 1);
        rst_n = 1'b0; #1;
        check("rr_sda_release", sda_oe, 0);
        check("rr_busy", busy, 0);
        host_sda = 1'b1; host_scl = 1'b1;
        wait_n(5); rst_n = 1'b1; wait_n(10);
        i2c_start();
        send_byte(8'h72, 0, ack);
        send_byte(8'h00, 0, ack);
        i2c_start();
        send_byte(8'h73, 0, ack); check("rr_ack", ack, 0);
        read_byte(1'b1, rd); check("rr_rd_00", rd, 8'h00);
        i2c_stop(); wait_n(Q);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
